// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, issues in-order word fetches, and buffers
// responses in a small PC-tagged queue that feeds decode.
//
// Ports
//   clk, rst           rising-edge clock, synchronous active-high reset
//   imem_req_valid     fetch request valid
//   imem_req_ready     memory accepts the request this cycle
//   imem_req_addr      word-aligned fetch address (the PC)
//   imem_rsp_valid     in-order response valid (no backpressure)
//   imem_rsp_data      returned instruction word
//   redirect_valid     flush and restart fetch at redirect_pc
//   redirect_pc        restart address, low two bits ignored
//   id_valid           head entry holds a returned instruction
//   id_ready           decode consumes the head this cycle
//   id_instr           head instruction, NOP when id_valid is low
//   id_pc              head PC, zero when id_valid is low
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  // Slots are used as a ring. Between head and fill they are FULL,
  // between fill and tail they are PENDING, the rest are FREE.
  logic [31:0]   pc_q, pc_d;
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] fill_q, fill_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] alloc_q, alloc_d;
  logic [CW-1:0] full_q, full_d;
  logic [CW-1:0] infl_q, infl_d;
  logic [CW-1:0] drop_q, drop_d;

  logic [31:0] slot_pc_q    [DEPTH];
  logic [31:0] slot_instr_q [DEPTH];

  logic accept;
  logic rsp_ok;
  logic rsp_drop;
  logic rsp_fill;
  logic deq;

  logic unused_rpc_lsb;
  assign unused_rpc_lsb = ^redirect_pc[1:0];

  // Gating uses registered counts only, so a dequeue from a full
  // queue frees a slot for requests one cycle later.
  assign imem_req_valid = (alloc_q < CW'(DEPTH))
                       && (infl_q < CW'(DEPTH))
                       && !redirect_valid
                       && !rst;
  assign imem_req_addr  = pc_q;

  assign accept   = imem_req_valid && imem_req_ready;
  // A response with nothing outstanding is ignored.
  assign rsp_ok   = imem_rsp_valid && (infl_q != '0);
  assign rsp_drop = rsp_ok && (drop_q != '0);
  assign rsp_fill = rsp_ok && (drop_q == '0)
                 && !redirect_valid;

  assign id_valid = (full_q != '0);
  assign id_instr = id_valid ? slot_instr_q[head_q] : NOP;
  assign id_pc    = id_valid ? slot_pc_q[head_q] : 32'h0;

  // Decode is flushed by the same redirect, so its handshake is void.
  assign deq = id_valid && id_ready && !redirect_valid;

  always_comb begin
    pc_d    = pc_q;
    head_d  = head_q;
    fill_d  = fill_q;
    tail_d  = tail_q;
    alloc_d = alloc_q;
    full_d  = full_q;
    infl_d  = infl_q;
    drop_d  = drop_q;
    if (redirect_valid) begin
      pc_d    = {redirect_pc[31:2], 2'b00};
      head_d  = '0;
      fill_d  = '0;
      tail_d  = '0;
      alloc_d = '0;
      full_d  = '0;
      // Everything still outstanding after this cycle is stale.
      infl_d  = infl_q - CW'(rsp_ok);
      drop_d  = infl_q - CW'(rsp_ok);
    end else begin
      if (accept) begin
        pc_d   = pc_q + 32'd4;
        tail_d = tail_q + AW'(1);
      end
      if (rsp_fill) begin
        fill_d = fill_q + AW'(1);
      end
      if (deq) begin
        head_d = head_q + AW'(1);
      end
      alloc_d = alloc_q + CW'(accept) - CW'(deq);
      full_d  = full_q + CW'(rsp_fill) - CW'(deq);
      infl_d  = infl_q + CW'(accept) - CW'(rsp_ok);
      drop_d  = drop_q - CW'(rsp_drop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      head_q  <= '0;
      fill_q  <= '0;
      tail_q  <= '0;
      alloc_q <= '0;
      full_q  <= '0;
      infl_q  <= '0;
      drop_q  <= '0;
    end else begin
      pc_q    <= pc_d;
      head_q  <= head_d;
      fill_q  <= fill_d;
      tail_q  <= tail_d;
      alloc_q <= alloc_d;
      full_q  <= full_d;
      infl_q  <= infl_d;
      drop_q  <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      slot_pc_q[tail_q] <= pc_q;
    end
    if (rsp_fill && !rst) begin
      slot_instr_q[fill_q] <= imem_rsp_data;
    end
  end

  a_rsp_protocol: assert property (
    @(posedge clk) disable iff (rst)
    imem_rsp_valid |-> (infl_q != '0)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed table, corner sequences and random traffic
// for fetch_unit, checked against a queue-based reference model.
module tb_fetch_unit;

  localparam int          DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_instr;
  logic [31:0] id_pc;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instr       (id_instr),
    .id_pc          (id_pc)
  );

  int vec = 0;
  int miss = 0;
  int cyc = 0;

  bit          s_rqv, s_idv;
  logic [31:0] s_addr, s_pc, s_ins;

  typedef struct {
    logic [31:0] addr;
    int          rdy;
  } mreq_t;
  mreq_t memq[$];

  typedef struct {
    logic [31:0] pc;
    bit          full;
    logic [31:0] data;
  } ent_t;
  ent_t        mq[$];
  logic [31:0] m_pc;
  int          m_infl;
  int          m_drop;
  bit          m_known = 1'b0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0001;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    vec++;
    if (got !== exp) begin
      miss++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               nm, got, exp, cyc);
    end
  endtask

  task automatic model_update(input bit r, input bit acc, input bit ir,
                              input bit rv, input logic [31:0] rpc,
                              input bit rsp, input logic [31:0] data);
    bit hv;
    ent_t e;
    if (r) begin
      m_pc = RST_PC;
      mq.delete();
      m_infl = 0;
      m_drop = 0;
      m_known = 1'b1;
    end else if (rv) begin
      m_pc = {rpc[31:2], 2'b00};
      mq.delete();
      m_drop = m_infl - ((rsp && m_infl > 0) ? 1 : 0);
      m_infl = m_drop;
    end else begin
      hv = (mq.size() > 0) && mq[0].full;
      if (rsp && m_infl > 0) begin
        if (m_drop > 0) m_drop--;
        else begin
          for (int i = 0; i < mq.size(); i++) begin
            if (!mq[i].full) begin
              mq[i].full = 1'b1;
              mq[i].data = data;
              break;
            end
          end
        end
        m_infl--;
      end
      if (hv && ir) void'(mq.pop_front());
      if (acc) begin
        e.pc = m_pc;
        e.full = 1'b0;
        e.data = 32'h0;
        mq.push_back(e);
        m_pc = m_pc + 32'd4;
        m_infl++;
      end
    end
  endtask

  task automatic step(input bit r, input bit rr, input bit ir,
                      input bit rv, input logic [31:0] rpc,
                      input int lat);
    bit          e_rqv, e_idv, rsp;
    logic [31:0] e_ins, e_pc, rdata;
    @(negedge clk);
    rst = r;
    imem_req_ready = rr;
    id_ready = ir;
    redirect_valid = rv;
    redirect_pc = rpc;
    rsp = !r && (memq.size() > 0) && (memq[0].rdy <= cyc);
    rdata = rsp ? memf(memq[0].addr) : 32'h0;
    imem_rsp_valid = rsp;
    imem_rsp_data = rdata;
    e_rqv = (mq.size() < DEPTH) && (m_infl < DEPTH) && !rv && !r;
    e_idv = (mq.size() > 0) && mq[0].full;
    e_ins = e_idv ? mq[0].data : NOP;
    e_pc  = e_idv ? mq[0].pc : 32'h0;
    #1;
    s_rqv  = imem_req_valid;
    s_addr = imem_req_addr;
    s_idv  = id_valid;
    s_ins  = id_instr;
    s_pc   = id_pc;
    if (m_known) begin
      chk("req_valid", {31'b0, s_rqv}, {31'b0, e_rqv});
      chk("req_addr", s_addr, m_pc);
      chk("id_valid", {31'b0, s_idv}, {31'b0, e_idv});
      chk("id_instr", s_ins, e_ins);
      chk("id_pc", s_pc, e_pc);
    end
    @(posedge clk);
    if (rsp) void'(memq.pop_front());
    if (s_rqv && rr) memq.push_back('{addr: s_addr, rdy: cyc + lat});
    if (r) memq.delete();
    model_update(r, rr && e_rqv, ir, rv, rpc, rsp, rdata);
    cyc++;
  endtask

  task automatic run_until_idv(input int n, input bit ir);
    for (int i = 0; i < n; i++) begin
      step(0, 1, ir, 0, 32'h0, 1);
      if (s_idv) break;
    end
  endtask

  task automatic do_reset();
    step(1, 1, 1, 0, 32'h0, 1);
    step(1, 1, 1, 0, 32'h0, 1);
  endtask

  typedef struct {
    bit          r;
    bit          rr;
    bit          ir;
    bit          c;
    bit          erv;
    logic [31:0] ea;
    bit          eidv;
    logic [31:0] epc;
  } row_t;
  row_t tbl[$];

  function automatic void add(input bit r, input bit rr, input bit ir,
                              input bit c, input bit erv,
                              input logic [31:0] ea, input bit eidv,
                              input logic [31:0] epc);
    row_t x;
    x.r = r; x.rr = rr; x.ir = ir; x.c = c;
    x.erv = erv; x.ea = ea; x.eidv = eidv; x.epc = epc;
    tbl.push_back(x);
  endfunction

  initial begin
    int n;
    logic [31:0] exp;

    // streaming, then decode stall and release
    add(1,1,1,0, 0,32'h00,0,32'h00);
    add(1,1,1,1, 0,32'h00,0,32'h00);
    add(0,1,1,1, 1,32'h00,0,32'h00);
    add(0,1,1,1, 1,32'h04,0,32'h00);
    add(0,1,1,1, 1,32'h08,1,32'h00);
    add(0,1,1,1, 1,32'h0C,1,32'h04);
    add(0,1,1,1, 1,32'h10,1,32'h08);
    add(0,1,0,1, 1,32'h14,1,32'h0C);
    add(0,1,0,1, 1,32'h18,1,32'h0C);
    add(0,1,0,1, 0,32'h1C,1,32'h0C);
    add(0,1,0,1, 0,32'h1C,1,32'h0C);
    add(0,1,1,1, 0,32'h1C,1,32'h0C);
    add(0,1,1,1, 1,32'h1C,1,32'h10);
    add(0,1,1,1, 1,32'h20,1,32'h14);
    add(0,1,1,1, 1,32'h24,1,32'h18);
    add(0,1,1,1, 1,32'h28,1,32'h1C);
    // memory not ready: address held at 0x10
    add(1,1,1,0, 0,32'h00,0,32'h00);
    add(1,1,1,1, 0,32'h00,0,32'h00);
    add(0,1,1,1, 1,32'h00,0,32'h00);
    add(0,1,1,1, 1,32'h04,0,32'h00);
    add(0,1,1,1, 1,32'h08,1,32'h00);
    add(0,1,1,1, 1,32'h0C,1,32'h04);
    add(0,0,1,1, 1,32'h10,1,32'h08);
    add(0,0,1,1, 1,32'h10,1,32'h0C);
    add(0,0,1,1, 1,32'h10,0,32'h00);
    add(0,0,1,1, 1,32'h10,0,32'h00);
    add(0,0,1,1, 1,32'h10,0,32'h00);
    add(0,1,1,1, 1,32'h10,0,32'h00);
    add(0,1,1,1, 1,32'h14,0,32'h00);
    add(0,1,1,1, 1,32'h18,1,32'h10);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].r, tbl[i].rr, tbl[i].ir, 0, 32'h0, 1);
      if (tbl[i].c) begin
        chk($sformatf("t%0d_req_valid", i), {31'b0, s_rqv},
            {31'b0, tbl[i].erv});
        chk($sformatf("t%0d_addr", i), s_addr, tbl[i].ea);
        chk($sformatf("t%0d_id_valid", i), {31'b0, s_idv},
            {31'b0, tbl[i].eidv});
        chk($sformatf("t%0d_id_pc", i), s_pc, tbl[i].epc);
        chk($sformatf("t%0d_id_instr", i), s_ins,
            tbl[i].eidv ? memf(tbl[i].epc) : NOP);
      end
    end

    // decode stalled: exactly DEPTH requests, order kept on release
    do_reset();
    n = 0;
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 0, 0, 32'h0, 1);
      if (s_rqv) n++;
    end
    chk("h2_issued", n, DEPTH);
    exp = 32'h0;
    for (int i = 0; i < 12; i++) begin
      step(0, 1, 1, 0, 32'h0, 1);
      if (s_idv) begin
        chk("h2_order", s_pc, exp);
        exp = exp + 32'd4;
      end
    end
    chk("h2_drained", exp, 32'd48);

    // redirect with two in flight and one response in the same cycle
    do_reset();
    step(0, 1, 1, 0, 32'h0, 2);
    step(0, 1, 1, 0, 32'h0, 2);
    step(0, 1, 1, 1, 32'h103, 1);
    step(0, 1, 1, 0, 32'h0, 1);
    chk("h4_req_valid", {31'b0, s_rqv}, 32'd1);
    chk("h4_req_addr", s_addr, 32'h100);
    run_until_idv(10, 1);
    chk("h4_first_pc", s_idv ? s_pc : 32'hDEAD_BEEF, 32'h100);

    // redirect while head is full and decode ready
    do_reset();
    run_until_idv(10, 0);
    step(0, 1, 1, 1, 32'h200, 1);
    chk("h5_head_full", {31'b0, s_idv}, 32'd1);
    step(0, 1, 1, 0, 32'h0, 1);
    chk("h5_flushed", {31'b0, s_idv}, 32'd0);
    run_until_idv(10, 1);
    chk("h5_first_pc", s_idv ? s_pc : 32'hDEAD_BEEF, 32'h200);

    // PC wrap, then reset mid-stream
    step(0, 1, 1, 1, 32'hFFFF_FFFC, 1);
    step(0, 1, 1, 0, 32'h0, 1);
    chk("h6_addr_top", s_addr, 32'hFFFF_FFFC);
    step(0, 1, 1, 0, 32'h0, 1);
    chk("h6_addr_wrap", s_addr, 32'h0);
    run_until_idv(10, 1);
    chk("h6_first_pc", s_idv ? s_pc : 32'hDEAD_BEEF, 32'hFFFF_FFFC);
    step(0, 1, 1, 0, 32'h0, 1);
    step(1, 1, 1, 0, 32'h0, 1);
    chk("h6_rst_req_valid", {31'b0, s_rqv}, 32'd0);
    step(0, 1, 1, 0, 32'h0, 1);
    chk("h6_rst_addr", s_addr, RST_PC);
    chk("h6_rst_id_valid", {31'b0, s_idv}, 32'd0);
    chk("h6_rst_id_pc", s_pc, 32'h0);
    chk("h6_rst_id_instr", s_ins, NOP);

    // random traffic against the model
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(0, 499) == 0,
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 9) < 7,
           $urandom_range(0, 39) == 0,
           $urandom,
           int'($urandom_range(1, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
